// File: rtl/sin_pkg.sv
// rtl/sin_pkg.sv - shared types and constants for the sine measurement stage
// Contents:
//   SIN_W         sample width of the sine generator stream
//   meas_state_e  measurement FSM states (IDLE, ARM, MEAS)
//   sin_sample_t  signed sample type
//   sin_max/min   signed max/min helpers used by the peak/trough trackers
package sin_pkg;

    localparam int SIN_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } meas_state_e;

    typedef logic signed [SIN_W-1:0] sin_sample_t;

    function automatic sin_sample_t sin_max(input sin_sample_t a, input sin_sample_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic sin_sample_t sin_min(input sin_sample_t a, input sin_sample_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sin_zc_det.sv
// rtl/sin_zc_det.sv - rising zero-crossing detector for the signed sample stream
// Ports:
//   clk, resetb  clock, asynchronous active-low reset
//   clear        forces the remembered sign to 0 (held while the meter is idle)
//   sin_in       current signed sample
//   xing         combinational: previous sample negative, current sample non-negative
module sin_zc_det
    import sin_pkg::*;
(
    input  logic        clk,
    input  logic        resetb,
    input  logic        clear,
    input  sin_sample_t sin_in,
    output logic        xing
);

    logic prev_sign_q;
    logic prev_sign_d;

    always_comb begin
        prev_sign_d = clear ? 1'b0 : sin_in[SIN_W-1];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            prev_sign_q <= 1'b0;
        end else begin
            prev_sign_q <= prev_sign_d;
        end
    end

    assign xing = prev_sign_q & ~sin_in[SIN_W-1];

endmodule

// File: rtl/sin_meter.sv
// rtl/sin_meter.sv - period / peak / trough meter for the sine generator output
// Build option: define SIN_METER_TROUGH_EN to track the per-period minimum;
// otherwise trough_out is a constant zero and no trough logic exists.
// Ports:
//   clk, resetb   clock, asynchronous active-low reset
//   en            measurement enable
//   sin_in        signed sample, one per clock
//   meas_ready    consumer accepts the held result
//   meas_valid    result held in the output register
//   period_out    cycles between consecutive rising crossings (saturating)
//   peak_out      signed maximum sample of the period
//   trough_out    signed minimum sample of the period (or 0)
//   overflow      period counter saturated during this period
//   dropped       results were lost since the previously accepted one
module sin_meter
    import sin_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               en,
    input  logic signed [8:0]  sin_in,
    input  logic               meas_ready,
    output logic               meas_valid,
    output logic [CNT_W-1:0]   period_out,
    output logic signed [8:0]  peak_out,
    output logic signed [8:0]  trough_out,
    output logic               overflow,
    output logic               dropped
);

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sin_sample_t      peak_q, peak_d;
    logic             ovf_q, ovf_d;

    logic             valid_q, valid_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    sin_sample_t      peak_out_q, peak_out_d;
    logic             ovf_out_q, ovf_out_d;
    logic             dropped_q, dropped_d;
    logic             drop_acc_q, drop_acc_d;

`ifdef SIN_METER_TROUGH_EN
    sin_sample_t      trough_q, trough_d;
    sin_sample_t      trough_out_q, trough_out_d;
`endif

    logic xing;
    logic zc_clear;
    logic emit;
    logic xfer;

    assign zc_clear = (state_q == ST_IDLE);

    sin_zc_det u_zc (
        .clk    (clk),
        .resetb (resetb),
        .clear  (zc_clear),
        .sin_in (sin_in),
        .xing   (xing)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        ovf_d   = ovf_q;
`ifdef SIN_METER_TROUGH_EN
        trough_d = trough_q;
`endif
        emit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM, ST_MEAS: begin
                if (!en) begin
                    // Partial period is abandoned; ARM will wait for a fresh crossing.
                    state_d = ST_IDLE;
                end else if (xing) begin
                    // The crossing sample both closes the current period and
                    // opens the next one, so back-to-back periods lose no cycle.
                    emit    = (state_q == ST_MEAS);
                    state_d = ST_MEAS;
                    cnt_d   = CNT_W'(1);
                    peak_d  = sin_in;
                    ovf_d   = 1'b0;
`ifdef SIN_METER_TROUGH_EN
                    trough_d = sin_in;
`endif
                end else if (state_q == ST_MEAS) begin
                    if (&cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    peak_d = sin_max(peak_q, sin_in);
`ifdef SIN_METER_TROUGH_EN
                    trough_d = sin_min(trough_q, sin_in);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single-entry output register; a result arriving while the previous one is
    // still unaccepted is discarded and remembered in drop_acc.
    always_comb begin
        valid_d      = valid_q;
        period_out_d = period_out_q;
        peak_out_d   = peak_out_q;
        ovf_out_d    = ovf_out_q;
        dropped_d    = dropped_q;
        drop_acc_d   = drop_acc_q;
`ifdef SIN_METER_TROUGH_EN
        trough_out_d = trough_out_q;
`endif
        xfer = valid_q & meas_ready;

        if (emit) begin
            if (!valid_q || xfer) begin
                valid_d      = 1'b1;
                period_out_d = cnt_q;
                peak_out_d   = peak_q;
                ovf_out_d    = ovf_q;
                dropped_d    = drop_acc_q;
                drop_acc_d   = 1'b0;
`ifdef SIN_METER_TROUGH_EN
                trough_out_d = trough_q;
`endif
            end else begin
                drop_acc_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            peak_q       <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
            period_out_q <= '0;
            peak_out_q   <= '0;
            ovf_out_q    <= 1'b0;
            dropped_q    <= 1'b0;
            drop_acc_q   <= 1'b0;
`ifdef SIN_METER_TROUGH_EN
            trough_q     <= '0;
            trough_out_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            peak_q       <= peak_d;
            ovf_q        <= ovf_d;
            valid_q      <= valid_d;
            period_out_q <= period_out_d;
            peak_out_q   <= peak_out_d;
            ovf_out_q    <= ovf_out_d;
            dropped_q    <= dropped_d;
            drop_acc_q   <= drop_acc_d;
`ifdef SIN_METER_TROUGH_EN
            trough_q     <= trough_d;
            trough_out_q <= trough_out_d;
`endif
        end
    end

    assign meas_valid = valid_q;
    assign period_out = period_out_q;
    assign peak_out   = peak_out_q;
    assign overflow   = ovf_out_q;
    assign dropped    = dropped_q;

`ifdef SIN_METER_TROUGH_EN
    assign trough_out = trough_out_q;
`else
    assign trough_out = 9'sh000;
`endif

endmodule

// File: tb/tb_sin_meter.sv
// tb/tb_sin_meter.sv - scoreboard bench for sin_meter with a period-level reference model
module tb_sin_meter;

    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SIN_METER_TROUGH_EN
    localparam bit TR_EN = 1'b1;
`else
    localparam bit TR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetb;
    logic              en;
    logic signed [8:0] sin_in;
    logic              meas_ready;
    logic              meas_valid;
    logic [CNT_W-1:0]  period_out;
    logic signed [8:0] peak_out;
    logic signed [8:0] trough_out;
    logic              overflow;
    logic              dropped;

    sin_meter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .en         (en),
        .sin_in     (sin_in),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .period_out (period_out),
        .peak_out   (peak_out),
        .trough_out (trough_out),
        .overflow   (overflow),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int peak;
        int trough;
        bit ovf;
        bit dropped;
    } res_t;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: a period is open from one accepted rising
    // crossing to the next while enable stays continuously high.
    bit en_last, act_last;
    int samp_last;
    bit open;
    int open_len, pk, tr;
    bit m_valid, m_drop_acc;

    task automatic model_reset();
        en_last = 0; act_last = 0; samp_last = 0;
        open = 0; open_len = 0; pk = 0; tr = 0;
        m_valid = 0; m_drop_acc = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit e, input int s, input bit rdy);
        bit   act, xing, emit, xfer;
        res_t r;
        act  = en_last;   // meter is armed/measuring iff en was high last clock
        xing = act && act_last && (samp_last < 0) && (s >= 0) && e;
        emit = 0;
        r = '{0, 0, 0, 0, 0};
        if (!act || !e) begin
            open = 0;
        end else if (xing) begin
            if (open) begin
                emit     = 1;
                r.period = (open_len > CMAX) ? CMAX : open_len;
                r.ovf    = (open_len > CMAX);
                r.peak   = pk;
                r.trough = TR_EN ? tr : 0;
            end
            open = 1; open_len = 1; pk = s; tr = s;
        end else if (open) begin
            open_len++;
            if (s > pk) pk = s;
            if (s < tr) tr = s;
        end
        xfer = m_valid && rdy;
        if (emit) begin
            if (!m_valid || xfer) begin
                r.dropped = m_drop_acc;
                exp_q.push_back(r);
                m_drop_acc = 0;
                m_valid = 1;
            end else begin
                m_drop_acc = 1;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
        act_last = act; en_last = e; samp_last = s;
    endtask

    task automatic cyc(input bit e, input int s, input bit rdy);
        en = e; sin_in = s[8:0]; meas_ready = rdy;
        @(posedge clk);
        if (resetb) model_step(e, s, rdy);
        #1;
    endtask

    // Monitor: pops one expected result per observed transfer and checks
    // that held data does not change while stalled.
    bit      hold_pending = 0;
    longint  hold_snap;
    always @(negedge clk) begin
        longint cur;
        res_t   r;
        cur = {period_out, 9'(peak_out), 9'(trough_out), overflow, dropped};
        if (!resetb) begin
            hold_pending = 0;
        end else begin
            if (hold_pending && meas_valid) check("hold_stable", cur, hold_snap);
            if (meas_valid && meas_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("period", period_out, r.period);
                    check("peak", int'(peak_out), r.peak);
                    check("trough", int'(trough_out), r.trough);
                    check("overflow", overflow, r.ovf);
                    check("dropped", dropped, r.dropped);
                end
            end
            hold_pending = meas_valid && !meas_ready;
            hold_snap    = cur;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, meas_valid, 0);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_peak"}, int'(peak_out), 0);
        check({tag, "_trough"}, int'(trough_out), 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_dropped"}, dropped, 0);
    endtask

    int pat[7] = '{-1, -1, -1, 10, 4, 2, 1};

    task automatic run_pattern(input int periods, input bit rdy);
        for (int p = 0; p < periods; p++)
            for (int i = 0; i < 7; i++) cyc(1, pat[i], rdy);
    endtask

    initial begin
        int waited;
        resetb = 0; en = 0; sin_in = 0; meas_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;
        resetb = 1;

        // Directed 7-cycle waveform, consumer always ready.
        repeat (2) cyc(0, 0, 1);
        run_pattern(12, 1);

        // Stall across several emits, then release: later result flags the loss.
        run_pattern(5, 0);
        run_pattern(4, 1);

        // Enable dropped mid-period; re-arm must start from a fresh crossing.
        for (int i = 0; i < 5; i++) cyc(1, pat[i], 1);
        repeat (3) cyc(0, 50, 1);
        cyc(1, 2, 1); cyc(1, 3, 1);
        run_pattern(4, 1);

        // Long period to exercise counter saturation, then a normal one.
        cyc(1, -5, 1);
        for (int i = 0; i < 80; i++) cyc(1, i % 100, 1);
        cyc(1, -256, 1);
        run_pattern(3, 1);

        // Randomized segments: shaped periods, fully random bursts, extremes,
        // random backpressure and occasional enable drops.
        for (int seg = 0; seg < 160; seg++) begin
            int p, k, s;
            bit rdy, e;
            p = $urandom_range(2, 90);
            k = $urandom_range(1, p - 1);
            for (int i = 0; i < p; i++) begin
                if (seg % 10 == 9) s = $urandom_range(0, 511) - 256;
                else if (i < k)    s = $urandom_range(0, 255);
                else               s = -$urandom_range(1, 256);
                if ($urandom_range(0, 40) == 0) s = ($urandom_range(0, 1) != 0) ? 255 : -256;
                rdy = ($urandom_range(0, 3) != 0);
                e   = ($urandom_range(0, 299) != 0);
                cyc(e, s, rdy);
            end
        end

        // Reset while a result is pending.
        run_pattern(2, 1);
        waited = 0;
        while (!m_valid && waited < 100) begin
            cyc(1, pat[waited % 7], 0);
            waited++;
        end
        check("pending_before_reset", m_valid, 1);
        cyc(1, pat[0], 0);
        #2 resetb = 0;
        model_reset();
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        check_zero_outputs("reset_next_cycle");
        @(posedge clk); #1;
        resetb = 1;
        run_pattern(6, 1);

        // Drain and confirm every expected result was delivered.
        repeat (10) cyc(0, 0, 1);
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/sin_meter.md
# sin_meter

Measurement stage directly downstream of the sine generator: consumes its 9-bit two's-complement sample stream, detects rising zero crossings, and reports the period (in clock cycles) and positive peak of each complete cycle. Results are delivered through a single-entry valid/ready output register to the control/debug logic that checks the programmed period selection.

## Interface
Parameters:
- CNT_W, 20, width of period counter; sin_gen maximum period 1024*256 = 262144 fits in 19 bits.

Ports:
- clk  in  1  512 MHz clock, same domain as sin_gen
- resetb  in  1  reset; one clock, asynchronous, active-low
- en  in  1  measurement enable, active high
- sin_in  in  9  signed sample from sin_gen, one per clock
- meas_ready  in  1  consumer accepts result
- meas_valid  out  1  result available
- period_out  out  CNT_W  cycles between consecutive rising crossings
- peak_out  out  9  signed maximum sample within the period
- trough_out  out  9  signed minimum sample (see Configuration)
- overflow  out  1  period counter saturated during this period
- dropped  out  1  at least one result was lost since the previous accepted one

## Operation
- Rising crossing (xing): previous sample sign bit = 1 and current sin_in sign bit = 0; previous-sample register cleared to 0 on reset and in IDLE.
- FSM states: IDLE, ARM, MEAS.
  - IDLE: en=0. On en=1 -> ARM.
  - ARM: wait for first xing; on xing -> MEAS, cnt<=1, peak<=sin_in, trough<=sin_in.
  - MEAS: each non-xing cycle: cnt<=cnt+1 saturating at all-ones (sets ovf_acc), peak<=max(peak,sin_in) signed, trough<=min. On xing: emit result {cnt, peak, trough, ovf_acc}, then restart accumulators with the crossing sample exactly as in ARM (back-to-back periods, no lost cycle).
  - en=0 in ARM or MEAS -> IDLE next cycle; partial measurement discarded, no result emitted.
- Output register: on emit, if meas_valid=0 or (meas_valid & meas_ready) same cycle, load result, meas_valid<=1, dropped<=drop_acc, drop_acc<=0. Otherwise new result discarded, drop_acc<=1, held result unchanged.
- meas_valid & meas_ready with no emit -> meas_valid<=0. Output data stable while meas_valid=1 and meas_ready=0.
- Pending result survives en=0; only reset clears it.
- Signed compare on full 9 bits; 9'h100 (-256) is a legal minimum.

## Timing
- Reset: meas_valid=0, period_out=0, peak_out=0, trough_out=0, overflow=0, dropped=0, FSM=IDLE, drop_acc=0.
- Latency: result visible (meas_valid=1) in the cycle after the closing xing sample is presented.
- period_out = number of samples from opening xing sample (inclusive) to closing xing sample (exclusive); the closing sample belongs to the next period's peak/trough.
- Transfer occurs on rising clk with meas_valid & meas_ready; meas_ready may be held high permanently.
- en sampled each clk; the cycle en rises is spent in IDLE, ARM active from the next cycle.

## Configuration
- SIN_METER_TROUGH_EN defined: trough tracking per Operation, trough_out carries the period minimum.
- Not defined: no trough register or comparator; trough_out tied to 9'h000 constantly.

## Structure
- Shared package sin_pkg: SIN_W=9, state enum for IDLE/ARM/MEAS, sin_sample_t (logic signed [SIN_W-1:0]).
- One sub-module sin_zc_det: holds previous-sample sign, outputs xing; cleared by a clear input (IDLE).
- Everything else (FSM, accumulators, output register) in sin_meter.

## Test plan
- Reset mid-MEAS with meas_valid=1 -> all outputs 0 next cycle, FSM IDLE, no spurious result after release.
- en=1, sin_in repeating {-1,-1,-1,+10,+4,+2,+1} (xing at +10), meas_ready=1 -> each period after the first xing yields period_out=7, peak_out=10, trough_out=-1 (macro on) / 0 (off), overflow=0.
- Real sin_gen with period_sel=0 then 3 -> period_out=1024 then 4096, peak_out equal to LUT maximum, trough_out its negation.
- CNT_W=4, stimulus period 20 -> period_out=15, overflow=1; next 7-cycle period -> overflow=0.
- meas_ready=0 across three emits -> first result held unchanged; after meas_ready=1 the following accepted result shows dropped=1, the next dropped=0.
- en dropped mid-period then re-raised -> ARM waits for a fresh xing; first result is a full period, no partial count.
